// File: rtl/idct_block_scheduler_if.sv
// idct_block_scheduler_if: sched control plus FS / MM / WS start-done handshakes and block indices
interface idct_block_scheduler_if;
  logic       sched_start, sched_done;
  logic       FS_start, FS_done, MM_start, MM_done, T_S, WS_start, WS_done;
  logic [4:0] FS_row, WS_row;
  logic [5:0] FS_col, WS_col;
  modport master (
    input  sched_start, FS_done, MM_done, WS_done,
    output sched_done, FS_start, FS_row, FS_col, MM_start, T_S, WS_start, WS_row, WS_col
  );
  modport slave (
    output sched_start, FS_done, MM_done, WS_done,
    input  sched_done, FS_start, FS_row, FS_col, MM_start, T_S, WS_start, WS_row, WS_col
  );
endinterface

// File: rtl/idct_block_scheduler.sv
// idct_block_scheduler: walks every 8x8 block, overlapping CT with WS(k-1) and CS with FS(k+1).
// Defining IDCT_SCHED_PERF_EN adds the perf_stall_cycles counter port.
module idct_block_scheduler #(
  parameter int BLK_ROWS = 30,
  parameter int BLK_COLS = 40
) (
  input  logic                   CLOCK_50_I,
  input  logic                   Resetn,
  idct_block_scheduler_if.master bus
`ifdef IDCT_SCHED_PERF_EN
  ,
  output logic [15:0]            perf_stall_cycles
`endif
);
  typedef enum logic [2:0] {IDLE, F0, CT, CS, LO, DONE} state_t;
  state_t     state_q, state_d;
  logic [4:0] row_q, row_d, fs_row_q, fs_row_d, ws_row_q, ws_row_d, nrow;
  logic [5:0] col_q, col_d, fs_col_q, fs_col_d, ws_col_q, ws_col_d, ncol;
  logic       fs_go_q, fs_go_d, mm_go_q, mm_go_d, ws_go_q, ws_go_d;
  logic       fs_f_q, fs_f_d, mm_f_q, mm_f_d, ws_f_q, ws_f_d;
  logic       fs_dn_q, mm_dn_q, ws_dn_q;
  logic       first, last, col_end;

  assign col_end = col_q == 6'(BLK_COLS - 1);
  assign last    = col_end && row_q == 5'(BLK_ROWS - 1);
  assign first   = row_q == '0 && col_q == '0;
  assign ncol    = col_end ? '0 : col_q + 6'd1;
  assign nrow    = col_end ? row_q + 5'd1 : row_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    fs_row_d = fs_row_q;
    fs_col_d = fs_col_q;
    ws_row_d = ws_row_q;
    ws_col_d = ws_col_q;
    fs_go_d  = 1'b0;
    mm_go_d  = 1'b0;
    ws_go_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.sched_start) begin
        state_d  = F0;
        row_d    = '0;
        col_d    = '0;
        fs_row_d = '0;
        fs_col_d = '0;
        fs_go_d  = 1'b1;
      end
      F0: if (fs_f_q) begin
        state_d = CT;
        mm_go_d = 1'b1;
      end
      CT: if (mm_f_q && (first || ws_f_q)) begin
        state_d  = CS;
        mm_go_d  = 1'b1;
        fs_go_d  = !last;
        fs_row_d = last ? fs_row_q : nrow;
        fs_col_d = last ? fs_col_q : ncol;
      end
      CS: if (mm_f_q && (last || fs_f_q)) begin
        state_d  = last ? LO : CT;
        mm_go_d  = !last;
        ws_go_d  = 1'b1;
        ws_row_d = row_q;
        ws_col_d = col_q;
        row_d    = last ? row_q : nrow;
        col_d    = last ? col_q : ncol;
      end
      LO:      state_d = ws_f_q ? DONE : LO;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a new start retires the unit's previous completion
    fs_f_d = !fs_go_d && (fs_f_q || (bus.FS_done && !fs_dn_q));
    mm_f_d = !mm_go_d && (mm_f_q || (bus.MM_done && !mm_dn_q));
    ws_f_d = !ws_go_d && (ws_f_q || (bus.WS_done && !ws_dn_q));
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn)
    if (!Resetn) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      fs_row_q <= '0;
      fs_col_q <= '0;
      ws_row_q <= '0;
      ws_col_q <= '0;
      fs_go_q  <= 1'b0;
      mm_go_q  <= 1'b0;
      ws_go_q  <= 1'b0;
      fs_f_q   <= 1'b0;
      mm_f_q   <= 1'b0;
      ws_f_q   <= 1'b0;
      fs_dn_q  <= 1'b0;
      mm_dn_q  <= 1'b0;
      ws_dn_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      fs_row_q <= fs_row_d;
      fs_col_q <= fs_col_d;
      ws_row_q <= ws_row_d;
      ws_col_q <= ws_col_d;
      fs_go_q  <= fs_go_d;
      mm_go_q  <= mm_go_d;
      ws_go_q  <= ws_go_d;
      fs_f_q   <= fs_f_d;
      mm_f_q   <= mm_f_d;
      ws_f_q   <= ws_f_d;
      fs_dn_q  <= bus.FS_done;
      mm_dn_q  <= bus.MM_done;
      ws_dn_q  <= bus.WS_done;
    end

  assign bus.FS_start   = fs_go_q;
  assign bus.MM_start   = mm_go_q;
  assign bus.WS_start   = ws_go_q;
  assign bus.T_S        = state_q == CS;
  assign bus.sched_done = state_q == DONE;
  assign bus.FS_row     = fs_row_q;
  assign bus.FS_col     = fs_col_q;
  assign bus.WS_row     = ws_row_q;
  assign bus.WS_col     = ws_col_q;

`ifdef IDCT_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;
  logic        stall;

  assign stall = mm_f_q && ((state_q == CT && !first && !ws_f_q) || (state_q == CS && !last && !fs_f_q));

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && bus.sched_start) perf_d = '0;
    else if (stall && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge CLOCK_50_I or negedge Resetn)
    if (!Resetn) perf_q <= '0;
    else perf_q <= perf_d;

  assign perf_stall_cycles = perf_q;
`endif
endmodule

// File: tb/tb_idct_block_scheduler.sv
// tb_idct_block_scheduler: stub units with random latency/level behaviour, checked against a block-order trace model
module tb_idct_block_scheduler;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  idct_block_scheduler_if ifa ();
  idct_block_scheduler_if ifb ();
`ifdef IDCT_SCHED_PERF_EN
  logic [15:0] perf_a, perf_b;
`endif

  idct_block_scheduler #(.BLK_ROWS(1), .BLK_COLS(1)) ua (
    .CLOCK_50_I(clk), .Resetn(rst_a), .bus(ifa)
`ifdef IDCT_SCHED_PERF_EN
    , .perf_stall_cycles(perf_a)
`endif
  );
  idct_block_scheduler #(.BLK_ROWS(2), .BLK_COLS(3)) ub (
    .CLOCK_50_I(clk), .Resetn(rst_b), .bus(ifb)
`ifdef IDCT_SCHED_PERF_EN
    , .perf_stall_cycles(perf_b)
`endif
  );

  int n_chk = 0, n_fail = 0;
  logic [5:0] st;
  logic [5:0] dn;
  int lat[6];
  bit lvl[6];
  int cnt[6];
  logic [31:0] exp_q[$], obs_q[$];
  int obs_cyc[$], done_cyc[$];
  int rise_q[3][$];
  bit timed_out;

  assign st = {ifb.WS_start, ifb.MM_start, ifb.FS_start, ifa.WS_start, ifa.MM_start, ifa.FS_start};
  assign ifa.FS_done = dn[0];
  assign ifa.MM_done = dn[1];
  assign ifa.WS_done = dn[2];
  assign ifb.FS_done = dn[3];
  assign ifb.MM_done = dn[4];
  assign ifb.WS_done = dn[5];

  // unit stubs: pulse mode raises done for one cycle; level mode holds done until the next op's start
  initial begin
    dn = '0;
    for (int u = 0; u < 6; u++) cnt[u] = 0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 6; u++) begin
        if (!(u < 3 ? rst_a : rst_b)) begin
          dn[u] = 1'b0;
          cnt[u] = 0;
        end else begin
          if (!lvl[u]) dn[u] = 1'b0;
          if (st[u]) cnt[u] = lat[u];
          else if (cnt[u] > 0) begin
            if (cnt[u] == lat[u]) dn[u] = 1'b0;
            cnt[u]--;
            if (cnt[u] == 0) dn[u] = 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [31:0] enc(bit f, bit m, bit ts, bit w, int fr, int fc, int wr, int wc);
    logic [4:0] a, c;
    logic [5:0] b, e;
    a = w ? 5'(wr) : 5'd0;
    b = w ? 6'(wc) : 6'd0;
    c = f ? 5'(fr) : 5'd0;
    e = f ? 6'(fc) : 6'd0;
    return {6'd0, a, b, c, e, f, m, ts & m, w};
  endfunction

  function automatic void build_exp(int r, int c);
    int n;
    n = r * c;
    exp_q.delete();
    exp_q.push_back(enc(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(enc(0, 1, 0, k > 0, 0, 0, (k - 1) / c, (k - 1) % c));
      exp_q.push_back(enc(k < n - 1, 1, 1, 0, (k + 1) / c, (k + 1) % c, 0, 0));
    end
    exp_q.push_back(enc(0, 0, 0, 1, 0, 0, (n - 1) / c, (n - 1) % c));
  endfunction

  // step i may start one cycle after the last awaited unit of step i-1 shows its done rise
  function automatic int exp_time(int i);
    logic [31:0] p;
    int t, r;
    bit used;
    t = -1;
    if (i < 1 || i > exp_q.size() || i - 1 >= obs_cyc.size()) return -1;
    p = exp_q[i-1];
    for (int u = 0; u < 3; u++) begin
      used = (u == 0) ? p[3] : (u == 1) ? p[2] : p[0];
      if (used) begin
        r = -1;
        for (int j = 0; j < rise_q[u].size(); j++)
          if (r < 0 && rise_q[u][j] > obs_cyc[i-1]) r = rise_q[u][j];
        if (r < 0) return -1;
        t = r > t ? r : t;
      end
    end
    return t + 1;
  endfunction

  task automatic sstart(input int d, input logic v);
    if (d == 0) ifa.sched_start = v;
    else ifb.sched_start = v;
  endtask

  task automatic rand_units(input int d);
    for (int u = 3 * d; u < 3 * d + 3; u++) begin
      lvl[u] = 1'($urandom_range(0, 1));
      lat[u] = lvl[u] ? int'($urandom_range(2, 9)) : int'($urandom_range(1, 9));
    end
  endtask

  task automatic run_plane(input int d, input int inj_step, input int abort_step);
    bit prev[3];
    bit f, m, ts, w, sd, injected;
    int fr, fc, wr, wc, tail, cyc;
    obs_q.delete();
    obs_cyc.delete();
    done_cyc.delete();
    for (int u = 0; u < 3; u++) begin
      rise_q[u].delete();
      prev[u] = dn[3*d+u];
    end
    cyc = 0;
    tail = -1;
    timed_out = 0;
    injected = 0;
    sstart(d, 1'b1);
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      sstart(d, 1'b0);
      if (d == 0) begin
        f = ifa.FS_start; m = ifa.MM_start; ts = ifa.T_S; w = ifa.WS_start; sd = ifa.sched_done;
        fr = ifa.FS_row; fc = ifa.FS_col; wr = ifa.WS_row; wc = ifa.WS_col;
      end else begin
        f = ifb.FS_start; m = ifb.MM_start; ts = ifb.T_S; w = ifb.WS_start; sd = ifb.sched_done;
        fr = ifb.FS_row; fc = ifb.FS_col; wr = ifb.WS_row; wc = ifb.WS_col;
      end
      if (f || m || w) begin
        obs_q.push_back(enc(f, m, ts, w, fr, fc, wr, wc));
        obs_cyc.push_back(cyc);
      end
      for (int u = 0; u < 3; u++) begin
        if (dn[3*d+u] && !prev[u]) rise_q[u].push_back(cyc);
        prev[u] = dn[3*d+u];
      end
      if (sd) done_cyc.push_back(cyc);
      if (inj_step >= 0 && !injected && obs_q.size() == inj_step + 1) begin
        sstart(d, 1'b1);
        injected = 1;
      end
      if (abort_step >= 0 && obs_q.size() == abort_step + 1) return;
      if (done_cyc.size() > 0 && tail < 0) tail = 8;
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
      if (cyc >= 4000) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({ifa.FS_start, ifa.MM_start, ifa.T_S, ifa.WS_start, ifa.sched_done, ifa.FS_row, ifa.FS_col, ifa.WS_row, ifa.WS_col} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: outputs not zero (FS_start %b MM_start %b WS_start %b done %b), required all 0", ifa.FS_start, ifa.MM_start, ifa.WS_start, ifa.sched_done);
    end
    n_chk++;
    if ({ifb.FS_start, ifb.MM_start, ifb.T_S, ifb.WS_start, ifb.sched_done, ifb.FS_row, ifb.FS_col, ifb.WS_row, ifb.WS_col} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: outputs not zero (FS_start %b MM_start %b WS_start %b done %b), required all 0", ifb.FS_start, ifb.MM_start, ifb.WS_start, ifb.sched_done);
    end
    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
  endtask

  task automatic test_single_block();
    for (int u = 0; u < 3; u++) begin lat[u] = 5; lvl[u] = 0; end
    build_exp(1, 1);
    run_plane(0, -1, -1);
    n_chk++;
    if (timed_out || obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL single steps: got %0d (timeout %0b) required %0d", obs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single step%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_chk++;
        if (obs_cyc[i] !== exp_time(i)) begin
          n_fail++;
          $display("FAIL single time%0d: got cycle %0d required %0d", i, obs_cyc[i], exp_time(i));
        end
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== exp_time(exp_q.size())) begin
      n_fail++;
      $display("FAIL single done: got %0d pulses required 1 at cycle %0d", done_cyc.size(), exp_time(exp_q.size()));
    end
  endtask

  task automatic test_plane_random();
    for (int it = 0; it < 4; it++) begin
      rand_units(1);
      build_exp(2, 3);
      run_plane(1, -1, -1);
      n_chk++;
      if (timed_out || obs_q.size() !== exp_q.size()) begin
        n_fail++;
        $display("FAIL plane%0d steps: got %0d (timeout %0b) required %0d", it, obs_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL plane%0d step%0d: got %h required %h", it, i, obs_q[i], exp_q[i]);
        end
        if (i > 0) begin
          n_chk++;
          if (obs_cyc[i] !== exp_time(i)) begin
            n_fail++;
            $display("FAIL plane%0d time%0d: got cycle %0d required %0d", it, i, obs_cyc[i], exp_time(i));
          end
        end
      end
      n_chk++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== exp_time(exp_q.size())) begin
        n_fail++;
        $display("FAIL plane%0d done: got %0d pulses required 1 at cycle %0d", it, done_cyc.size(), exp_time(exp_q.size()));
      end
    end
  endtask

  task automatic test_fetch_lag();
    lat[3] = 23; lvl[3] = 0;
    lat[4] = 3;  lvl[4] = 1;
    lat[5] = 2;  lvl[5] = 0;
    build_exp(2, 3);
    run_plane(1, -1, -1);
    n_chk++;
    if (timed_out || obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL lag steps: got %0d (timeout %0b) required %0d", obs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lag step%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_chk++;
        if (obs_cyc[i] !== exp_time(i)) begin
          n_fail++;
          $display("FAIL lag time%0d: got cycle %0d required %0d", i, obs_cyc[i], exp_time(i));
        end
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL lag done: got %0d pulses required 1", done_cyc.size());
    end
`ifdef IDCT_SCHED_PERF_EN
    n_chk++;
    if (perf_b !== 16'd100) begin
      n_fail++;
      $display("FAIL lag perf: got %0d required 100", perf_b);
    end
`endif
  endtask

  task automatic test_coincident_done();
    lat[3] = 2; lvl[3] = 0;
    lat[4] = 4; lvl[4] = 0;
    lat[5] = 4; lvl[5] = 0;
    build_exp(2, 3);
    run_plane(1, -1, -1);
    n_chk++;
    if (timed_out || obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL coinc steps: got %0d (timeout %0b) required %0d", obs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL coinc step%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
      if (i > 0) begin
        n_chk++;
        if (obs_cyc[i] !== exp_time(i)) begin
          n_fail++;
          $display("FAIL coinc time%0d: got cycle %0d required %0d", i, obs_cyc[i], exp_time(i));
        end
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL coinc done: got %0d pulses required 1", done_cyc.size());
    end
  endtask

  task automatic test_abort_restart();
    rand_units(1);
    build_exp(2, 3);
    run_plane(1, -1, 6);
    #2;
    rst_b = 1'b0;
    #1;
    n_chk++;
    if ({ifb.FS_start, ifb.MM_start, ifb.T_S, ifb.WS_start, ifb.sched_done, ifb.FS_row, ifb.FS_col, ifb.WS_row, ifb.WS_col} !== '0) begin
      n_fail++;
      $display("FAIL abort outputs: T_S %b FS %0d,%0d WS %0d,%0d required all 0", ifb.T_S, ifb.FS_row, ifb.FS_col, ifb.WS_row, ifb.WS_col);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (ifb.sched_done !== 1'b0 || ifb.T_S !== 1'b0) begin
      n_fail++;
      $display("FAIL abort held: sched_done %b T_S %b required 0", ifb.sched_done, ifb.T_S);
    end
    rst_b = 1'b1;
    rand_units(1);
    run_plane(1, -1, -1);
    n_chk++;
    if (timed_out || obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL restart steps: got %0d (timeout %0b) required %0d", obs_q.size(), timed_out, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL restart step%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL restart done: got %0d pulses required 1", done_cyc.size());
    end
  endtask

  task automatic test_start_ignored();
    int nws;
    rand_units(1);
    build_exp(2, 3);
    run_plane(1, 3, -1);
    nws = 0;
    foreach (obs_q[i]) nws += int'(obs_q[i][0]);
    n_chk++;
    if (timed_out || nws !== 6) begin
      n_fail++;
      $display("FAIL ignore ws_count: got %0d (timeout %0b) required 6", nws, timed_out);
    end
    n_chk++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL ignore steps: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ignore step%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (done_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL ignore done: got %0d pulses required 1", done_cyc.size());
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.sched_start = 1'b0;
    ifb.sched_start = 1'b0;
    for (int u = 0; u < 6; u++) begin lat[u] = 3; lvl[u] = 0; end
    test_reset();
    test_single_block();
    test_plane_random();
    test_fetch_lag();
    test_coincident_done();
    test_abort_restart();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
